corr_peak_detect: RTL and testbench

- Downstream consumer of the fast Fourier correlation output stream.
- Scans one correlation frame of complex samples and computes I^2+Q^2 for each sample.
- Tracks the maximum magnitude and its sample index, then emits one result beat per frame on an AXI-Stream-style output.
- Feeds the timing/sync control logic that decides alignment between func_1 and func_2.

---
 rtl/corr_peak_detect.sv | 181 ++++++++++++++++++
 tb/tb_corr_peak_detect.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/corr_peak_detect.sv
// Correlation peak detector: squares each complex sample of one frame, tracks the largest
// I^2+Q^2 and its first index, and emits one {index, magnitude} beat per frame.
module corr_peak_detect #(
  parameter int FRAME_W = 14,
  parameter int DATA_W  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [FRAME_W-1:0]    frame_len,
  input  logic                  start,
  output logic                  idle,
  input  logic [2*DATA_W-1:0]   corr_tdata,
  input  logic                  corr_tvalid,
  output logic                  corr_tready,
  output logic [63:0]           peak_tdata,
  output logic                  peak_tvalid,
  input  logic                  peak_tready,
  output logic [1:0]            dbg_state
);

  localparam int MAG_W = 2 * DATA_W;
  localparam int PAD_W = 64 - FRAME_W - MAG_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_idle;
  logic               r_tready;
  logic               r_tvalid;
  logic [63:0]        r_tdata;
  logic [FRAME_W-1:0] r_len;
  logic [FRAME_W-1:0] r_cnt;
  logic [MAG_W-1:0]   r_max;
  logic [FRAME_W-1:0] r_idx;

  logic               r_s1_valid;
  logic               r_s1_first;
  logic               r_s1_last;
  logic [MAG_W-1:0]   r_s1_ii;
  logic [MAG_W-1:0]   r_s1_qq;
  logic [FRAME_W-1:0] r_s1_idx;

  logic               r_s2_valid;
  logic               r_s2_first;
  logic               r_s2_last;
  logic [MAG_W-1:0]   r_s2_mag;
  logic [FRAME_W-1:0] r_s2_idx;

  logic signed [MAG_W-1:0] w_i;
  logic signed [MAG_W-1:0] w_q;
  logic signed [MAG_W-1:0] w_ii;
  logic signed [MAG_W-1:0] w_qq;
  logic                    w_accept;
  logic                    w_last_in;
  logic                    w_take;
  logic [MAG_W-1:0]        w_max_nx;
  logic [FRAME_W-1:0]      w_idx_nx;

  // Both streams use AXI-Stream semantics: a beat transfers on a rising edge where
  // valid and ready are both high; a source holds valid and data stable until then.
  assign idle        = r_idle;
  assign corr_tready = r_tready;
  assign peak_tvalid = r_tvalid;
  assign peak_tdata  = r_tdata;
  assign dbg_state   = r_state;

  // Components are sign-extended to full product width so each square is exact.
  assign w_i  = {{DATA_W{corr_tdata[DATA_W-1]}}, corr_tdata[DATA_W-1:0]};
  assign w_q  = {{DATA_W{corr_tdata[2*DATA_W-1]}}, corr_tdata[2*DATA_W-1:DATA_W]};
  assign w_ii = w_i * w_i;
  assign w_qq = w_q * w_q;

  assign w_accept  = corr_tvalid & r_tready;
  assign w_last_in = (r_cnt == (r_len - 1'b1));

  // Strict greater-than keeps the earliest index on ties.
  assign w_take   = r_s2_valid & (r_s2_first | (r_s2_mag > r_max));
  assign w_max_nx = w_take ? r_s2_mag : r_max;
  assign w_idx_nx = w_take ? r_s2_idx : r_idx;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ii    <= '0;
      r_s1_qq    <= '0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= (r_cnt == '0);
        r_s1_last  <= w_last_in;
        r_s1_ii    <= w_ii;
        r_s1_qq    <= w_qq;
        r_s1_idx   <= r_cnt;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_mag   <= '0;
      r_s2_idx   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_mag   <= r_s1_ii + r_s1_qq;
        r_s2_idx   <= r_s1_idx;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_idle   <= 1'b1;
      r_tready <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_max    <= '0;
      r_idx    <= '0;
    end else begin
      if (r_s2_valid) begin
        r_max <= w_max_nx;
        r_idx <= w_idx_nx;
      end
      case (r_state)
        S_IDLE: begin
          if (start && (frame_len != '0)) begin
            r_len    <= frame_len;
            r_cnt    <= '0;
            r_max    <= '0;
            r_idx    <= '0;
            r_idle   <= 1'b0;
            r_tready <= 1'b1;
            r_state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_in) begin
              r_tready <= 1'b0;
              r_state  <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last sample's compare lands on this edge, so publish the merged result.
          if (r_s2_valid && r_s2_last) begin
            r_tdata  <= {{PAD_W{1'b0}}, w_idx_nx, w_max_nx};
            r_tvalid <= 1'b1;
            r_state  <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (peak_tready) begin
            r_tvalid <= 1'b0;
            r_idle   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_peak_detect.sv
// Directed and randomized frames for corr_peak_detect, checked against a peak-search
// model built from the sample arrays.
module tb_corr_peak_detect;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [13:0] frame_len = '0;
  logic        start = 1'b0;
  logic [31:0] corr_tdata = '0;
  logic        corr_tvalid = 1'b0;
  logic        peak_tready = 1'b0;
  logic        idle;
  logic        corr_tready;
  logic [63:0] peak_tdata;
  logic        peak_tvalid;
  logic [1:0]  dbg_state;

  logic signed [15:0] si [0:63];
  logic signed [15:0] sq [0:63];
  logic [63:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  corr_peak_detect #(.FRAME_W(14), .DATA_W(16)) dut (
    .aclk(aclk), .areset(areset), .frame_len(frame_len), .start(start), .idle(idle),
    .corr_tdata(corr_tdata), .corr_tvalid(corr_tvalid), .corr_tready(corr_tready),
    .peak_tdata(peak_tdata), .peak_tvalid(peak_tvalid), .peak_tready(peak_tready),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference: first index of the largest I^2+Q^2 over the first n samples.
  function automatic logic [63:0] golden(input int n);
    longint best = -1;
    longint m;
    int bi = 0;
    for (int k = 0; k < n; k++) begin
      m = longint'(si[k]) * longint'(si[k]) + longint'(sq[k]) * longint'(sq[k]);
      if (m > best) begin
        best = m;
        bi = k;
      end
    end
    return {18'd0, 14'(bi), 32'(best)};
  endfunction

  task automatic set_sample(input int k, input int i_v, input int q_v);
    si[k] = 16'(i_v);
    sq[k] = 16'(q_v);
  endtask

  task automatic start_frame(input int len);
    frame_len = 14'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_idle", idle, 0);
    chk("start_tready", corr_tready, 1);
  endtask

  task automatic drive_samples(input int n, input bit rand_valid, input bit start_mid);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < n && guard < 2000) begin
      corr_tdata  = {sq[k], si[k]};
      corr_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_mid && k == n / 2) begin
        start = 1'b1;
        frame_len = 14'd2;
      end else begin
        start = 1'b0;
      end
      acc = corr_tvalid && corr_tready;
      step();
      if (acc) k++;
      guard++;
    end
    start = 1'b0;
    corr_tvalid = 1'b0;
    if (k < n) chk("accept_timeout", 64'(k), 64'(n));
  endtask

  // Called one step after the final accept edge; checks result latency, stall, handshake.
  task automatic finish_frame(input int stall);
    logic [63:0] exp_v;
    exp_v = exp_q.pop_front();
    peak_tready = (stall == 0);
    chk("tready_drop", corr_tready, 0);
    chk("tvalid_T1", peak_tvalid, 0);
    step();
    chk("tvalid_T2", peak_tvalid, 0);
    step();
    chk("tvalid_T3", peak_tvalid, 1);
    chk("peak_tdata", peak_tdata, exp_v);
    for (int c = 0; c < stall; c++) begin
      step();
      chk("stall_tdata", peak_tdata, exp_v);
      chk("stall_tvalid", peak_tvalid, 1);
      chk("stall_tready", corr_tready, 0);
    end
    peak_tready = 1'b1;
    step();
    chk("tvalid_after_hs", peak_tvalid, 0);
    chk("idle_after_hs", idle, 1);
    peak_tready = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) step();
    chk("rst_idle", idle, 1);
    chk("rst_tready", corr_tready, 0);
    chk("rst_tvalid", peak_tvalid, 0);
    chk("rst_tdata", peak_tdata, 0);
    areset = 1'b0;
    step();

    // directed frame of 8, tie between idx 1 and 3
    set_sample(0, 0, 0);  set_sample(1, 3, 4);  set_sample(2, 1, 1);  set_sample(3, -5, 0);
    set_sample(4, 0, 2);  set_sample(5, 1, 0);  set_sample(6, 0, 0);  set_sample(7, 2, 2);
    exp_q.push_back({18'd0, 14'd1, 32'd25});
    start_frame(8);
    drive_samples(8, 1'b0, 1'b0);
    finish_frame(0);

    // single most-negative sample
    set_sample(0, -32768, -32768);
    exp_q.push_back(64'h0000_0000_8000_0000);
    start_frame(1);
    drive_samples(1, 1'b0, 1'b0);
    finish_frame(0);

    // 16 random small samples, throttled input, output stalled 10 cycles
    for (int k = 0; k < 16; k++)
      set_sample(k, int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4);
    exp_q.push_back(golden(16));
    start_frame(16);
    drive_samples(16, 1'b1, 1'b0);
    finish_frame(10);

    // zero-length start ignored
    frame_len = 14'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_idle", idle, 1);
    chk("len0_tready", corr_tready, 0);
    repeat (5) step();
    chk("len0_tvalid", peak_tvalid, 0);
    chk("len0_idle_late", idle, 1);

    // reset mid-frame, then a clean frame of (1,0)
    for (int k = 0; k < 10; k++) set_sample(k, 100 + k, 7);
    start_frame(10);
    drive_samples(5, 1'b0, 1'b0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("midrst_idle", idle, 1);
    chk("midrst_tready", corr_tready, 0);
    chk("midrst_tvalid", peak_tvalid, 0);
    for (int k = 0; k < 4; k++) set_sample(k, 1, 0);
    exp_q.push_back({18'd0, 14'd0, 32'd1});
    start_frame(4);
    drive_samples(4, 1'b0, 1'b0);
    finish_frame(0);

    // two consecutive frames with a start pulse while busy
    set_sample(0, 1, 0); set_sample(1, 2, 0); set_sample(2, 5, 5); set_sample(3, 0, 3);
    exp_q.push_back({18'd0, 14'd2, 32'd50});
    start_frame(4);
    drive_samples(4, 1'b0, 1'b1);
    finish_frame(0);
    set_sample(0, 7, 7); set_sample(1, 1, 1); set_sample(2, -7, 7); set_sample(3, 0, 0);
    exp_q.push_back({18'd0, 14'd0, 32'd98});
    start_frame(4);
    drive_samples(4, 1'b0, 1'b0);
    finish_frame(3);

    // random frames, full-range data
    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++)
        set_sample(k, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      exp_q.push_back(golden(len));
      start_frame(len);
      drive_samples(len, 1'b1, 1'b0);
      finish_frame($urandom_range(0, 3));
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
